alu_share_arbiter: RTL

//  Shares one combinational ALU between two requesters: port 0 is the main execute path, port 1 is the branch/address unit.

---
 rtl/alu_share_arbiter_pkg.sv | 34 +++
 rtl/alu_share_arbiter_alu.sv | 43 ++++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: default widths, ALU control codes,
// FSM state encoding and a small one-hot helper.
// No ports; imported by alu_share_arbiter and alu_share_arbiter_alu.
package alu_share_arbiter_pkg;

  // Default datapath geometry.
  localparam int WIDTH_DEF  = 32;
  localparam int CTRL_W_DEF = 4;
  localparam int MAX_OP_DEF = 9;

  // ALU control codes. Code 0 is deliberately unused so that an all-zero
  // control word from an idle or mis-decoded issue slot is flagged as illegal.
  localparam int ALU_AND = 1;
  localparam int ALU_OR  = 2;
  localparam int ALU_ADD = 3;
  localparam int ALU_SUB = 4;
  localparam int ALU_SLT = 5;  // signed set-less-than, result is 0 or 1
  localparam int ALU_XOR = 6;
  localparam int ALU_NOR = 7;
  localparam int ALU_SLL = 8;  // shift amount from low bits of operand 2
  localparam int ALU_SRL = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Two-requester one-hot decode of a requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purpose : the existing single-cycle combinational ALU shared by both requesters.
// Latency : purely combinational, no state.
// Ports   : InputData1/InputData2 operands, ALU_Control op code, ALU_Result, Zero (result == 0).
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic [WIDTH-1:0]  InputData1,
  input  logic [WIDTH-1:0]  InputData2,
  input  logic [CTRL_W-1:0] ALU_Control,
  output logic [WIDTH-1:0]  ALU_Result,
  output logic              Zero
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            slt;

  assign shamt = InputData2[SH_W-1:0];
  assign slt   = $signed(InputData1) < $signed(InputData2);

  always_comb begin
    ALU_Result = '0;
    case (ALU_Control)
      CTRL_W'(ALU_AND): ALU_Result = InputData1 & InputData2;
      CTRL_W'(ALU_OR):  ALU_Result = InputData1 | InputData2;
      CTRL_W'(ALU_ADD): ALU_Result = InputData1 + InputData2;
      CTRL_W'(ALU_SUB): ALU_Result = InputData1 - InputData2;
      CTRL_W'(ALU_SLT): ALU_Result = {{(WIDTH-1){1'b0}}, slt};
      CTRL_W'(ALU_XOR): ALU_Result = InputData1 ^ InputData2;
      CTRL_W'(ALU_NOR): ALU_Result = ~(InputData1 | InputData2);
      CTRL_W'(ALU_SLL): ALU_Result = InputData1 << shamt;
      CTRL_W'(ALU_SRL): ALU_Result = InputData1 >> shamt;
      default:          ALU_Result = '0;
    endcase
  end

  assign Zero = (ALU_Result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one ALU between requester 0 (execute) and requester 1 (branch/address) with round-robin grant.
// Latency : accept at edge N, response valid after edge N+1; at least 3 cycles per op, one op in flight.
// Backpressure: req_ready only in IDLE for the granted requester; response held stable until rsp_ready[owner].
// Ports   : clk, reset_n (sync, active-low); req_valid/req_ready/req_a/req_b/req_ctrl per requester (packed, req 0 in
//           the low slice); rsp_valid/rsp_ready per requester; shared rsp_result/rsp_zero/rsp_err bus; busy.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int MAX_OP = MAX_OP_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*WIDTH-1:0]    req_a,
  input  logic [2*WIDTH-1:0]    req_b,
  input  logic [2*CTRL_W-1:0]   req_ctrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [CTRL_W-1:0] MAX_CODE = CTRL_W'(MAX_OP);

  state_t             state;
  logic               last_grant;
  logic               owner;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CTRL_W-1:0]  ctrl_q;

  logic               pref;
  logic               grant;
  logic               grant_vld;
  logic               accept;
  logic               ctrl_ok;
  logic [WIDTH-1:0]   grant_a;
  logic [WIDTH-1:0]   grant_b;
  logic [CTRL_W-1:0]  grant_ctrl;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;

  // Round-robin: the requester that was not served last has priority; if it is
  // idle the other one is served, so a lone requester is never stalled.
  assign pref = ~last_grant;

  always_comb begin
    grant     = pref;
    grant_vld = 1'b0;
    if (req_valid[pref]) begin
      grant     = pref;
      grant_vld = 1'b1;
    end else if (req_valid[last_grant]) begin
      grant     = last_grant;
      grant_vld = 1'b1;
    end
  end

  // Ready is withheld while reset is asserted so nothing looks accepted during reset.
  assign req_ready = (reset_n && (state == IDLE) && grant_vld) ? onehot2(grant) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign grant_a    = grant ? req_a[2*WIDTH-1:WIDTH]     : req_a[WIDTH-1:0];
  assign grant_b    = grant ? req_b[2*WIDTH-1:WIDTH]     : req_b[WIDTH-1:0];
  assign grant_ctrl = grant ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];

  // The ALU only ever sees the latched operands, so requester inputs may move
  // freely once the request has been taken.
  alu_share_arbiter_alu #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .InputData1  (a_q),
    .InputData2  (b_q),
    .ALU_Control (ctrl_q),
    .ALU_Result  (alu_result),
    .Zero        (alu_zero)
  );

  assign ctrl_ok = (ctrl_q != '0) && (ctrl_q <= MAX_CODE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= grant_a;
            b_q        <= grant_b;
            ctrl_q     <= grant_ctrl;
            owner      <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Illegal codes never expose ALU output; they report a clean error.
          if (ctrl_ok) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response.
          if (rsp_ready[owner]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP) ? onehot2(owner) : 2'b00;
  assign busy      = (state != IDLE);

endmodule
